// File: rtl/io_ccff_loader_if.sv
// io_ccff_loader_if -- word handshake, serial chain and status bundle for
// the IO-tile ccff loader. The master side is whoever supplies configuration
// words and closes the chain loop. The slave side is the loader.
interface io_ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_shift_en;
  logic              IO_ISOL_N;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, error
  );

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, error
  );
endinterface

// File: rtl/io_ccff_loader.sv
// io_ccff_loader -- serialises configuration words into the IO-tile ccff
// chain while the pads are isolated.
// Sequence: IDLE -> ISOLATE (guard) -> SHIFT -> [VERIFY] -> RELEASE (guard) -> IDLE.
// Optional feature macro CCFF_READBACK_EN adds a CRC-8 (poly 0x07) readback
// pass that recirculates the chain and flags a sticky error on mismatch.
module io_ccff_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int ISOL_HOLD = 2
) (
  input  logic             prog_clk,
  input  logic             pReset,
  io_ccff_loader_if.slave  bus
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BCW    = $clog2(CHAIN_LEN + 1);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int KCW    = $clog2(WORD_W + 1);
  localparam int HCW    = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_SHIFT   = 3'd2,
`ifdef CCFF_READBACK_EN
    S_VERIFY  = 3'd3,
`endif
    S_RELEASE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [HCW-1:0]    hold_q, hold_d;     // guard-cycle counter
  logic [BCW-1:0]    bit_q, bit_d;       // bits shifted in current pass
  logic [WCW-1:0]    word_q, word_d;     // words accepted this load
  logic [WORD_W-1:0] buf_q, buf_d;       // unshifted bits, LSB next out
  logic [KCW-1:0]    bcnt_q, bcnt_d;     // number of valid bits in buf_q
  logic              isol_n_q, isol_n_d;
  logic              done_q, done_d;

  logic              ready_c, xfer_c, from_buf_c, shift_c, head_c;

`ifdef CCFF_READBACK_EN
  logic [7:0]        crc_wr_q, crc_wr_d; // CRC of bits written into chain
  logic [7:0]        crc_rb_q, crc_rb_d; // CRC of bits read back from tail
  logic [7:0]        crc_rb_nxt;
  logic              err_q, err_d;

  // Serial CRC-8, poly x^8+x^2+x+1, MSB-first feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  // Tail is only consumed by the readback pass.
  logic unused_tail;
  assign unused_tail = bus.ccff_tail;
`endif

  // State and datapath registers; reset aborts any load and leaves pads isolated.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      buf_q    <= '0;
      bcnt_q   <= '0;
      isol_n_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_wr_q <= '0;
      crc_rb_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      buf_q    <= buf_d;
      bcnt_q   <= bcnt_d;
      isol_n_q <= isol_n_d;
      done_q   <= done_d;
`ifdef CCFF_READBACK_EN
      crc_wr_q <= crc_wr_d;
      crc_rb_q <= crc_rb_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state, word handshake and shift control.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    bit_d      = bit_q;
    word_d     = word_q;
    buf_d      = buf_q;
    bcnt_d     = bcnt_q;
    isol_n_d   = isol_n_q;
    done_d     = 1'b0;
    ready_c    = 1'b0;
    xfer_c     = 1'b0;
    from_buf_c = 1'b0;
    shift_c    = 1'b0;
    head_c     = 1'b0;
`ifdef CCFF_READBACK_EN
    crc_wr_d   = crc_wr_q;
    crc_rb_d   = crc_rb_q;
    crc_rb_nxt = crc8_step(crc_rb_q, bus.ccff_tail);
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_ISOLATE;
          hold_d   = '0;
          bit_d    = '0;
          word_d   = '0;
          buf_d    = '0;
          bcnt_d   = '0;
          isol_n_d = 1'b0;
`ifdef CCFF_READBACK_EN
          crc_wr_d = '0;
          crc_rb_d = '0;
          err_d    = 1'b0;
`endif
        end
      end
      S_ISOLATE: begin
        if (hold_q == HCW'(ISOL_HOLD - 1)) begin
          state_d = S_SHIFT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // A word is taken when the buffer drains this cycle; an empty buffer
        // forwards bit 0 of the incoming word straight to the chain.
        from_buf_c = (bcnt_q != '0);
        ready_c    = (bcnt_q <= KCW'(1)) && (word_q < WCW'(NWORDS));
        xfer_c     = ready_c && bus.cfg_valid;
        shift_c    = from_buf_c || xfer_c;
        head_c     = from_buf_c ? buf_q[0] : bus.cfg_data[0];
        if (xfer_c) begin
          word_d = word_q + 1'b1;
          if (from_buf_c) begin
            buf_d  = bus.cfg_data;
            bcnt_d = KCW'(WORD_W);
          end else begin
            buf_d  = bus.cfg_data >> 1;
            bcnt_d = KCW'(WORD_W - 1);
          end
        end else if (from_buf_c) begin
          buf_d  = buf_q >> 1;
          bcnt_d = bcnt_q - 1'b1;
        end
        if (shift_c) begin
          bit_d = bit_q + 1'b1;
`ifdef CCFF_READBACK_EN
          crc_wr_d = crc8_step(crc_wr_q, head_c);
`endif
          // Last chain bit: leftover upper bits of the final word are dropped.
          if (bit_q == BCW'(CHAIN_LEN - 1)) begin
            bit_d  = '0;
            buf_d  = '0;
            bcnt_d = '0;
            hold_d = '0;
`ifdef CCFF_READBACK_EN
            state_d = S_VERIFY;
`else
            state_d = S_RELEASE;
`endif
          end
        end
      end
`ifdef CCFF_READBACK_EN
      S_VERIFY: begin
        // Recirculate the chain so its content is unchanged after readback.
        shift_c  = 1'b1;
        head_c   = bus.ccff_tail;
        crc_rb_d = crc_rb_nxt;
        bit_d    = bit_q + 1'b1;
        if (bit_q == BCW'(CHAIN_LEN - 1)) begin
          bit_d   = '0;
          hold_d  = '0;
          state_d = S_RELEASE;
          if (crc_rb_nxt != crc_wr_q) err_d = 1'b1;
        end
      end
`endif
      S_RELEASE: begin
        if (hold_q == HCW'(ISOL_HOLD - 1)) begin
          state_d  = S_IDLE;
          hold_d   = '0;
          isol_n_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cfg_ready     = ready_c;
  assign bus.ccff_shift_en = shift_c;
  assign bus.ccff_head     = shift_c & head_c;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.IO_ISOL_N     = isol_n_q;
  assign bus.done          = done_q;
`ifdef CCFF_READBACK_EN
  assign bus.error         = err_q;
`else
  assign bus.error         = 1'b0;
`endif

endmodule
